// File: rtl/ld_str_multiple_addr_sequencer_pkg.sv
// Shared encodings and default widths for the load/store-multiple address sequencer.
// Mode and state enums live here so the top and any future siblings agree on them.
package ld_str_multiple_addr_sequencer_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int NREGS_DEF      = 16;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int WORD_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    MODE_IA = 2'b00,
    MODE_IB = 2'b01,
    MODE_DA = 2'b10,
    MODE_DB = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ld_str_multiple_addr_sequencer_lowest_set_bit_enc.sv
// Priority encoder returning the index of the lowest set bit of a register list,
// plus a valid flag that is low when the list is empty.
module lowest_set_bit_enc #(
  parameter int NREGS      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic [NREGS-1:0]      vec_i,
  output logic [REG_ADDR_W-1:0] idx_o,
  output logic                  valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan from the top so the last hit, the lowest index, wins.
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = REG_ADDR_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ld_str_multiple_addr_sequencer.sv
// Load/store-multiple address sequencer: one req/ack transfer per listed register,
// lowest register at the lowest address, then a one-cycle done/writeback pulse.
//
// state   | meaning
// IDLE    | waiting for an executed start
// XFER    | presenting transfers, advancing on each ack
// DONE    | one-cycle done pulse with optional base writeback
module ld_str_multiple_addr_sequencer
  import ld_str_multiple_addr_sequencer_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NREGS      = NREGS_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  instr_exec_in,
  input  logic [ADDR_W-1:0]     base_addr_in,
  input  logic [NREGS-1:0]      reg_list_in,
  input  logic [1:0]            mode_in,
  input  logic                  ld_str_in,
  input  logic                  wb_en_in,
  input  logic                  mem_ack_in,
  output logic                  mem_req_out,
  output logic [ADDR_W-1:0]     mem_addr_out,
  output logic                  mem_rd_wr_out,
  output logic [REG_ADDR_W-1:0] reg_addr_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  base_wb_en_out,
  output logic [ADDR_W-1:0]     base_wb_data_out
);

  localparam int CNT_W = $clog2(NREGS + 1);

  state_e                  state_q, state_d;
  logic [NREGS-1:0]        list_q, list_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       wb_data_q, wb_data_d;
  logic                    rd_wr_q, rd_wr_d;
  logic                    wb_en_q, wb_en_d;

  logic [NREGS-1:0]        sel_list;
  logic [NREGS-1:0]        list_rem;
  logic [REG_ADDR_W-1:0]   sel_idx;
  logic                    sel_valid;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       step;
  logic [ADDR_W-1:0]       span;
  logic [ADDR_W-1:0]       first_addr;
  logic [ADDR_W-1:0]       wb_val;
  logic                    start_ok;

  // In IDLE the encoder looks at the incoming list so its valid flag doubles as N > 0.
  assign sel_list = (state_q == ST_IDLE) ? reg_list_in : list_q;

  lowest_set_bit_enc #(
    .NREGS      (NREGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lsb_enc (
    .vec_i   (sel_list),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + CNT_W'(reg_list_in[i]);
    end
  end

  assign step     = ADDR_W'(WORD_BYTES);
  assign span     = ADDR_W'(cnt) * step;
  assign start_ok = start_in & instr_exec_in;
  assign list_rem = list_q & (list_q - NREGS'(1));
  assign wb_val   = mode_in[1] ? (base_addr_in - span) : (base_addr_in + span);

  always_comb begin
    first_addr = base_addr_in;
    case (mode_in)
      MODE_IA: first_addr = base_addr_in;
      MODE_IB: first_addr = base_addr_in + step;
      MODE_DA: first_addr = base_addr_in - span + step;
      MODE_DB: first_addr = base_addr_in - span;
      default: first_addr = base_addr_in;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    list_d    = list_q;
    addr_d    = addr_q;
    wb_data_d = wb_data_q;
    rd_wr_d   = rd_wr_q;
    wb_en_d   = wb_en_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          list_d    = reg_list_in;
          addr_d    = first_addr;
          rd_wr_d   = ld_str_in;
          wb_en_d   = wb_en_in & sel_valid;
          wb_data_d = wb_val;
          state_d   = sel_valid ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        if (mem_ack_in) begin
          list_d = list_rem;
          addr_d = addr_q + step;
          if (list_rem == '0) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q   <= ST_IDLE;
      list_q    <= '0;
      addr_q    <= '0;
      wb_data_q <= '0;
      rd_wr_q   <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      list_q    <= list_d;
      addr_q    <= addr_d;
      wb_data_q <= wb_data_d;
      rd_wr_q   <= rd_wr_d;
      wb_en_q   <= wb_en_d;
    end
  end

  assign mem_req_out      = (state_q == ST_XFER);
  assign mem_addr_out     = mem_req_out ? addr_q : '0;
  assign mem_rd_wr_out    = mem_req_out & rd_wr_q;
  assign reg_addr_out     = mem_req_out ? sel_idx : '0;
  assign busy_out         = (state_q != ST_IDLE);
  assign done_out         = (state_q == ST_DONE);
  assign base_wb_en_out   = done_out & wb_en_q;
  assign base_wb_data_out = base_wb_en_out ? wb_data_q : '0;

endmodule
